// File: rtl/tim_ctrl.sv
// tim_ctrl: register front-end for one general-purpose timer.
//
// Holds the timer configuration (CR/PSC/ARR/CCR/DIER), keeps the timer core
// in reset while disabled, watches the core's counter for update events,
// raises SR.UIF / irq and implements one-pulse mode.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   bus_req/we/addr/wdata  single-cycle peripheral bus request
//   bus_rdata/bus_ready    registered response, one cycle after bus_req
//   tim_rst             hold-reset to the timer core
//   tim_prescaler/counter_mode/counter_period/pulse/arpe  timer config
//   tim_counter         live counter value from the timer core
//   irq                 SR.UIF & DIER.UIE
//   dbg_state           current control FSM state (IDLE=0, ARM=1, RUN=2)
//
// Bus handshake: a request is a one-cycle bus_req pulse; bus_ready is high
// exactly one cycle later with bus_rdata valid. There is no back-pressure,
// so a new request may be presented in the same cycle bus_ready is high.
//
// Optional feature macro: TIM_CTRL_REPCNT_EN enables RCR (0x1C) and the
// repetition counter that divides flagged update events by RCR+1.
module tim_ctrl #(
    parameter int          ADDR_W  = 5,
    parameter logic [15:0] RST_PSC = 16'd0,
    parameter logic [15:0] RST_ARR = 16'hFFFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bus_req,
    input  logic              bus_we,
    input  logic [ADDR_W-1:0] bus_addr,
    input  logic [31:0]       bus_wdata,
    output logic [31:0]       bus_rdata,
    output logic              bus_ready,
    output logic              tim_rst,
    output logic [15:0]       tim_prescaler,
    output logic [1:0]        tim_counter_mode,
    output logic [15:0]       tim_counter_period,
    output logic [15:0]       tim_pulse,
    output logic              tim_arpe,
    input  logic [15:0]       tim_counter,
    output logic              irq,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_RUN  = 2'd2
    } state_e;

    localparam logic [ADDR_W-3:0] A_CR   = (ADDR_W-2)'(0);
    localparam logic [ADDR_W-3:0] A_PSC  = (ADDR_W-2)'(1);
    localparam logic [ADDR_W-3:0] A_ARR  = (ADDR_W-2)'(2);
    localparam logic [ADDR_W-3:0] A_CCR  = (ADDR_W-2)'(3);
    localparam logic [ADDR_W-3:0] A_SR   = (ADDR_W-2)'(4);
    localparam logic [ADDR_W-3:0] A_DIER = (ADDR_W-2)'(5);
    localparam logic [ADDR_W-3:0] A_CNT  = (ADDR_W-2)'(6);
`ifdef TIM_CTRL_REPCNT_EN
    localparam logic [ADDR_W-3:0] A_RCR  = (ADDR_W-2)'(7);
`endif

    state_e      state_q, state_d;
    logic        cen_q, cen_d, arpe_q, arpe_d, opm_q, opm_d;
    logic [1:0]  cms_q, cms_d;
    logic [15:0] psc_q, psc_d, arr_q, arr_d, ccr_q, ccr_d, prev_q;
    logic        uif_q, uif_d, uie_q, uie_d, prev_vld_q;
    logic [31:0] rdata_q, rdata_d, rd_mux;
    logic        ready_q, tim_rst_q, tim_rst_d;
    logic [ADDR_W-3:0] widx;
    logic        wr, hit, upd_evt, flag_evt;
    logic        unused_bits;
`ifdef TIM_CTRL_REPCNT_EN
    logic [7:0]  rcr_q, rcr_d, rep_q, rep_d;
`endif

    assign widx        = bus_addr[ADDR_W-1:2];
    assign wr          = bus_req && bus_we;
    assign unused_bits = ^{bus_addr[1:0], bus_wdata[31:16]};

    // Update-event detection. prev_q is only trusted from the second RUN
    // cycle on, since in the first one it still holds the reset-time value.
    always_comb begin
        hit = 1'b0;
        case (cms_q)
            2'b00:   hit = (tim_counter == 16'd0);
            2'b01:   hit = (prev_q == 16'd0);
            2'b10:   hit = (tim_counter == 16'd0);
            default: hit = 1'b0;
        endcase
        upd_evt = (state_q == S_RUN) && prev_vld_q && (tim_counter != prev_q) && hit;
    end

`ifdef TIM_CTRL_REPCNT_EN
    // Only the event that finds the repetition counter at zero is flagged.
    assign flag_evt = upd_evt && (rep_q == 8'd0);
`else
    assign flag_evt = upd_evt;
`endif

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (cen_q) state_d = S_ARM;
            S_ARM:   state_d = cen_q ? S_RUN : S_IDLE;
            S_RUN:   if (!cen_q) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Registered from the next state so ARM shows exactly one reset cycle.
        tim_rst_d = (state_d != S_RUN);
    end

    // Register file next state
    always_comb begin
        cen_d  = cen_q;
        cms_d  = cms_q;
        arpe_d = arpe_q;
        opm_d  = opm_q;
        psc_d  = psc_q;
        arr_d  = arr_q;
        ccr_d  = ccr_q;
        uie_d  = uie_q;
        uif_d  = uif_q;
        if (wr) begin
            case (widx)
                A_CR: begin
                    cen_d  = bus_wdata[0];
                    cms_d  = (bus_wdata[2:1] == 2'b11) ? 2'b00 : bus_wdata[2:1];
                    arpe_d = bus_wdata[3];
                    opm_d  = bus_wdata[4];
                end
                A_PSC:   psc_d = bus_wdata[15:0];
                A_ARR:   arr_d = bus_wdata[15:0];
                A_CCR:   ccr_d = bus_wdata[15:0];
                A_SR:    if (bus_wdata[0]) uif_d = 1'b0;
                A_DIER:  uie_d = bus_wdata[0];
                default: ;
            endcase
        end
        // Hardware wins over software: UIF set beats W1C, OPM stop beats CEN write.
        if (flag_evt) begin
            uif_d = 1'b1;
            if (opm_q) cen_d = 1'b0;
        end
    end

`ifdef TIM_CTRL_REPCNT_EN
    always_comb begin
        rcr_d = rcr_q;
        rep_d = rep_q;
        if (wr && (widx == A_RCR)) rcr_d = bus_wdata[7:0];
        if (state_q == S_ARM) rep_d = rcr_q;
        else if (upd_evt) rep_d = (rep_q == 8'd0) ? rcr_q : rep_q - 8'd1;
    end
`endif

    // Read mux
    always_comb begin
        rd_mux = 32'd0;
        case (widx)
            A_CR:    rd_mux = {27'd0, opm_q, arpe_q, cms_q, cen_q};
            A_PSC:   rd_mux = {16'd0, psc_q};
            A_ARR:   rd_mux = {16'd0, arr_q};
            A_CCR:   rd_mux = {16'd0, ccr_q};
            A_SR:    rd_mux = {31'd0, uif_q};
            A_DIER:  rd_mux = {31'd0, uie_q};
            A_CNT:   rd_mux = {16'd0, tim_counter};
`ifdef TIM_CTRL_REPCNT_EN
            A_RCR:   rd_mux = {24'd0, rcr_q};
`endif
            default: rd_mux = 32'd0;
        endcase
        rdata_d = (bus_req && !bus_we) ? rd_mux : 32'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cen_q      <= 1'b0;
            cms_q      <= 2'b00;
            arpe_q     <= 1'b0;
            opm_q      <= 1'b0;
            psc_q      <= RST_PSC;
            arr_q      <= RST_ARR;
            ccr_q      <= 16'd0;
            uif_q      <= 1'b0;
            uie_q      <= 1'b0;
            prev_q     <= 16'd0;
            prev_vld_q <= 1'b0;
            rdata_q    <= 32'd0;
            ready_q    <= 1'b0;
            tim_rst_q  <= 1'b1;
`ifdef TIM_CTRL_REPCNT_EN
            rcr_q      <= 8'd0;
            rep_q      <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            cen_q      <= cen_d;
            cms_q      <= cms_d;
            arpe_q     <= arpe_d;
            opm_q      <= opm_d;
            psc_q      <= psc_d;
            arr_q      <= arr_d;
            ccr_q      <= ccr_d;
            uif_q      <= uif_d;
            uie_q      <= uie_d;
            prev_q     <= tim_counter;
            prev_vld_q <= (state_q == S_RUN);
            rdata_q    <= rdata_d;
            ready_q    <= bus_req;
            tim_rst_q  <= tim_rst_d;
`ifdef TIM_CTRL_REPCNT_EN
            rcr_q      <= rcr_d;
            rep_q      <= rep_d;
`endif
        end
    end

    assign bus_rdata          = rdata_q;
    assign bus_ready          = ready_q;
    assign tim_rst            = tim_rst_q;
    assign tim_prescaler      = psc_q;
    assign tim_counter_mode   = cms_q;
    assign tim_counter_period = arr_q;
    assign tim_pulse          = ccr_q;
    assign tim_arpe           = arpe_q;
    assign irq                = uif_q & uie_q;
    assign dbg_state          = state_q;

endmodule

// File: tb/tb_tim_ctrl.sv
// tb_tim_ctrl: bench for tim_ctrl with a behavioural timer core model that
// drives tim_counter from the DUT's configuration outputs.
module tb_tim_ctrl;

    localparam logic [4:0] A_CR = 5'h00, A_PSC = 5'h04, A_ARR = 5'h08, A_CCR = 5'h0C;
    localparam logic [4:0] A_SR = 5'h10, A_DIER = 5'h14, A_CNT = 5'h18, A_RCR = 5'h1C;

    logic        clk = 1'b0;
    logic        rst;
    logic        bus_req, bus_we;
    logic [4:0]  bus_addr;
    logic [31:0] bus_wdata, bus_rdata;
    logic        bus_ready, tim_rst, tim_arpe, irq;
    logic [15:0] tim_prescaler, tim_counter_period, tim_pulse, tim_counter;
    logic [1:0]  tim_counter_mode, dbg_state;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    tim_ctrl dut (
        .clk(clk), .rst(rst),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_ready(bus_ready),
        .tim_rst(tim_rst), .tim_prescaler(tim_prescaler), .tim_counter_mode(tim_counter_mode),
        .tim_counter_period(tim_counter_period), .tim_pulse(tim_pulse), .tim_arpe(tim_arpe),
        .tim_counter(tim_counter), .irq(irq), .dbg_state(dbg_state)
    );

    // clock / reset block
    always #5 clk = ~clk;

    // Timer core model: up (00), down (01), centre-aligned (10); cleared by tim_rst.
    logic [15:0] m_cnt, m_prev, m_psc;
    logic        m_dir;
    assign tim_counter = m_cnt;
    always @(posedge clk) begin
        m_prev <= m_cnt;
        if (tim_rst) begin
            m_cnt <= 16'd0; m_psc <= 16'd0; m_dir <= 1'b0;
        end else if (m_psc != tim_prescaler) begin
            m_psc <= m_psc + 16'd1;
        end else begin
            m_psc <= 16'd0;
            case (tim_counter_mode)
                2'b01: m_cnt <= (m_cnt == 16'd0) ? tim_counter_period : m_cnt - 16'd1;
                2'b10: begin
                    if (!m_dir) begin
                        if (m_cnt >= tim_counter_period) begin m_dir <= 1'b1; m_cnt <= m_cnt - 16'd1; end
                        else m_cnt <= m_cnt + 16'd1;
                    end else begin
                        if (m_cnt == 16'd0) begin m_dir <= 1'b0; m_cnt <= m_cnt + 16'd1; end
                        else m_cnt <= m_cnt - 16'd1;
                    end
                end
                default: m_cnt <= (m_cnt >= tim_counter_period) ? 16'd0 : m_cnt + 16'd1;
            endcase
        end
    end

    // driver tasks: called at a negedge, return at the negedge of the ready cycle
    task automatic bus_wr(input logic [4:0] a, input logic [31:0] d);
        bus_req = 1'b1; bus_we = 1'b1; bus_addr = a; bus_wdata = d;
        @(negedge clk);
        bus_req = 1'b0; bus_we = 1'b0;
    endtask

    task automatic bus_rd(input logic [4:0] a, output logic [31:0] d, output logic r);
        bus_req = 1'b1; bus_we = 1'b0; bus_addr = a;
        @(negedge clk);
        d = bus_rdata; r = bus_ready;
        bus_req = 1'b0;
    endtask

    // Read with scoreboard: expectation queued on issue, popped on response.
    task automatic sb_read(input logic [4:0] a, input logic [31:0] e);
        logic [31:0] got, exp;
        logic rdy;
        exp_q.push_back(e);
        bus_rd(a, got, rdy);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp || rdy !== 1'b1) begin
            failures++;
            $display("FAIL read addr=%h got=%h ready=%b expected=%h ready=1", a, got, rdy, exp);
        end
    endtask

    // Scans for the model's wrap-to-zero step out of 'last'; bounded.
    task automatic wait_wrap(input logic [15:0] last, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (m_cnt == 16'd0 && m_prev == last) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic stop_clear();
        bus_wr(A_CR, 32'd0);
        repeat (3) @(negedge clk);
        bus_wr(A_SR, 32'd1);
    endtask

    task automatic test_reset();
        logic [31:0] exp_tab[8] = '{32'h0, 32'h0, 32'h0000FFFF, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        checks++;
        if (tim_rst !== 1'b1 || irq !== 1'b0 || dbg_state !== 2'd0 || bus_ready !== 1'b0
            || bus_rdata !== 32'd0) begin
            failures++;
            $display("FAIL reset_outputs tim_rst=%b irq=%b state=%0d ready=%b rdata=%h expected 1 0 0 0 0",
                     tim_rst, irq, dbg_state, bus_ready, bus_rdata);
        end
        for (int i = 0; i < 8; i++) sb_read(5'(i * 4), exp_tab[i]);
        @(negedge clk);
        checks++;
        if (bus_ready !== 1'b0) begin
            failures++;
            $display("FAIL ready_single_cycle got=%b expected=0", bus_ready);
        end
    endtask

    task automatic test_config();
        bus_wr(A_PSC, 32'hABCD_0005);
        bus_wr(A_CCR, 32'h0000_1234);
        bus_wr(A_CR, 32'h0000_0008);
        checks++;
        if (tim_prescaler !== 16'd5 || tim_pulse !== 16'h1234 || tim_arpe !== 1'b1) begin
            failures++;
            $display("FAIL config_outputs psc=%h pulse=%h arpe=%b expected 0005 1234 1",
                     tim_prescaler, tim_pulse, tim_arpe);
        end
        sb_read(A_PSC, 32'h5);
        sb_read(A_CR, 32'h8);
        bus_wr(A_PSC, 32'd0);
        bus_wr(A_CR, 32'd0);
    endtask

    task automatic test_up_count();
        bus_wr(A_ARR, 32'd4);
        bus_wr(A_DIER, 32'd1);
        bus_wr(A_CR, 32'd1);
        for (int k = 0; k <= 8; k++) begin
            if (k > 0) @(negedge clk);
            checks++;
            if (tim_rst !== (k < 2) || irq !== (k >= 8)) begin
                failures++;
                $display("FAIL up_count cycle=%0d tim_rst=%b irq=%b expected %b %b",
                         k, tim_rst, irq, (k < 2), (k >= 8));
            end
        end
        bus_wr(A_SR, 32'd1);
        for (int k = 9; k <= 13; k++) begin
            if (k > 9) @(negedge clk);
            checks++;
            if (irq !== (k >= 13)) begin
                failures++;
                $display("FAIL up_rewrap cycle=%0d irq=%b expected=%b", k, irq, (k >= 13));
            end
        end
        sb_read(A_CNT, 32'd1);
        stop_clear();
    endtask

    task automatic test_down_opm();
        logic exp_rst;
        bus_wr(A_ARR, 32'd3);
        bus_wr(A_CR, 32'h13);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            exp_rst = (k == 1) || (k == 5);
            checks++;
            if (tim_rst !== exp_rst || irq !== (k >= 4)) begin
                failures++;
                $display("FAIL down_opm cycle=%0d tim_rst=%b irq=%b expected %b %b",
                         k, tim_rst, irq, exp_rst, (k >= 4));
            end
        end
        sb_read(A_CR, 32'h12);
        repeat (3) @(negedge clk);
        sb_read(A_CNT, 32'd0);
        sb_read(A_SR, 32'd1);
        checks++;
        if (dbg_state !== 2'd0) begin
            failures++;
            $display("FAIL opm_state got=%0d expected=0", dbg_state);
        end
        stop_clear();
    endtask

    task automatic test_collisions();
        logic ok;
        bus_wr(A_ARR, 32'd4);
        bus_wr(A_CR, 32'd1);
        wait_wrap(16'd4, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL w1c_wrap_timeout got=0 expected=1"); end
        bus_wr(A_SR, 32'd1);
        sb_read(A_SR, 32'd1);
        stop_clear();
        bus_wr(A_CR, 32'h11);
        wait_wrap(16'd4, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL opm_wrap_timeout got=0 expected=1"); end
        bus_wr(A_CR, 32'h11);
        sb_read(A_CR, 32'h10);
        sb_read(A_SR, 32'd1);
        stop_clear();
    endtask

    task automatic test_center();
        bus_wr(A_ARR, 32'd2);
        bus_wr(A_CR, 32'h05);
        checks++;
        if (tim_counter_mode !== 2'b10) begin
            failures++;
            $display("FAIL center_mode got=%b expected=10", tim_counter_mode);
        end
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            checks++;
            if (irq !== (k == 7)) begin
                failures++;
                $display("FAIL center cycle=%0d irq=%b expected=%b", k, irq, (k == 7));
            end
        end
        bus_wr(A_SR, 32'd1);
        for (int k = 8; k <= 11; k++) begin
            if (k > 8) @(negedge clk);
            checks++;
            if (irq !== (k == 11)) begin
                failures++;
                $display("FAIL center2 cycle=%0d irq=%b expected=%b", k, irq, (k == 11));
            end
        end
        stop_clear();
        bus_wr(A_CR, 32'h06);
        sb_read(A_CR, 32'h0);
        checks++;
        if (tim_counter_mode !== 2'b00) begin
            failures++;
            $display("FAIL cms3_mode got=%b expected=00", tim_counter_mode);
        end
    endtask

    task automatic test_repcnt();
        int exp_k;
        logic [31:0] exp_rcr;
`ifdef TIM_CTRL_REPCNT_EN
        exp_k = 9; exp_rcr = 32'd2;
`else
        exp_k = 5; exp_rcr = 32'd0;
`endif
        bus_wr(A_ARR, 32'd1);
        bus_wr(A_RCR, 32'd2);
        sb_read(A_RCR, exp_rcr);
        bus_wr(A_CR, 32'd1);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            checks++;
            if (irq !== (k >= exp_k)) begin
                failures++;
                $display("FAIL repcnt cycle=%0d irq=%b expected=%b", k, irq, (k >= exp_k));
            end
        end
        stop_clear();
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp;
        bus_wr(A_ARR, 32'd7);
        bus_req = 1'b1; bus_we = 1'b0; bus_addr = A_ARR; exp_q.push_back(32'd7);
        @(negedge clk);
        exp = exp_q.pop_front();
        checks++;
        if (bus_ready !== 1'b1 || bus_rdata !== exp) begin
            failures++;
            $display("FAIL b2b_rd0 ready=%b rdata=%h expected 1 %h", bus_ready, bus_rdata, exp);
        end
        bus_we = 1'b1; bus_addr = A_CCR; bus_wdata = 32'h55;
        @(negedge clk);
        checks++;
        if (bus_ready !== 1'b1 || tim_pulse !== 16'h55) begin
            failures++;
            $display("FAIL b2b_wr ready=%b pulse=%h expected 1 0055", bus_ready, tim_pulse);
        end
        bus_we = 1'b0; bus_addr = A_CCR; exp_q.push_back(32'h55);
        @(negedge clk);
        exp = exp_q.pop_front();
        checks++;
        if (bus_ready !== 1'b1 || bus_rdata !== exp) begin
            failures++;
            $display("FAIL b2b_rd1 ready=%b rdata=%h expected 1 %h", bus_ready, bus_rdata, exp);
        end
        bus_req = 1'b0;
        @(negedge clk);
        checks++;
        if (bus_ready !== 1'b0) begin
            failures++;
            $display("FAIL b2b_idle ready=%b expected=0", bus_ready);
        end
    endtask

    task automatic test_reset_mid_run();
        bus_wr(A_ARR, 32'd4);
        bus_wr(A_CR, 32'h09);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (tim_rst !== 1'b1 || irq !== 1'b0 || dbg_state !== 2'd0 || tim_counter_period !== 16'hFFFF
            || tim_arpe !== 1'b0 || tim_pulse !== 16'd0) begin
            failures++;
            $display("FAIL mid_reset tim_rst=%b irq=%b state=%0d arr=%h arpe=%b pulse=%h expected 1 0 0 ffff 0 0000",
                     tim_rst, irq, dbg_state, tim_counter_period, tim_arpe, tim_pulse);
        end
        sb_read(A_CR, 32'd0);
        sb_read(A_DIER, 32'd0);
    endtask

    initial begin
        rst = 1'b1; bus_req = 1'b0; bus_we = 1'b0; bus_addr = '0; bus_wdata = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_config();
        test_up_count();
        test_down_opm();
        test_collisions();
        test_center();
        test_repcnt();
        test_back_to_back();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tim_ctrl.md
Name: tim_ctrl

Overview:
Memory-mapped control and status front-end for one general-purpose timer instance of the peripheral subsystem.
- Holds the timer's configuration registers and drives its configuration inputs.
- Gates the timer by holding it in reset while disabled.
- Detects update (overflow/underflow) events from the timer's counter output and raises a status flag and interrupt.
- Sequences one-pulse mode.
- Sits between the CPU's simple peripheral bus and the timer core.

Parameters:
ADDR_W, 5, byte-address width of the register window (registers at 0x00..0x1C, word aligned).
RST_PSC, 0, reset value of PSC.
RST_ARR, 16'hFFFF, reset value of ARR.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
bus_req  in  1  access request, one-cycle pulse
bus_we  in  1  1=write, 0=read
bus_addr  in  ADDR_W  byte address; bits [1:0] ignored
bus_wdata  in  32  write data
bus_rdata  out  32  read data, valid when bus_ready=1
bus_ready  out  1  access complete
tim_rst  out  1  hold-reset to timer core
tim_prescaler  out  16  = PSC
tim_counter_mode  out  2  = CR.CMS
tim_counter_period  out  16  = ARR
tim_pulse  out  16  = CCR
tim_arpe  out  1  = CR.ARPE
tim_counter  in  16  timer counter value
irq  out  1  level interrupt = SR.UIF & DIER.UIE

Behaviour:
- Register map:
  - 0x00 CR: [0] CEN, [2:1] CMS, [3] ARPE, [4] OPM.
  - 0x04 PSC[15:0].
  - 0x08 ARR[15:0].
  - 0x0C CCR[15:0].
  - 0x10 SR: [0] UIF, write-1-to-clear.
  - 0x14 DIER: [0] UIE.
  - 0x18 CNT: read-only, = tim_counter.
  - 0x1C RCR: see optional feature.
  - Unmapped addresses read 0; writes to them are ignored.
  - Unused register bits read 0.
- Reset values: CR=0, PSC=RST_PSC, ARR=RST_ARR, CCR=0, SR=0, DIER=0, bus_rdata=0, bus_ready=0, irq=0, tim_rst=1, FSM=IDLE.
- Bus timing:
  - bus_ready pulses exactly 1 cycle after bus_req; rdata is registered and valid in that cycle.
  - Write data takes effect on the cycle bus_ready is high.
  - No back-pressure. bus_req while bus_ready=1 is accepted normally, giving back-to-back single-cycle-spaced accesses.
- CMS write of 2'b11 stores 2'b00.
- FSM:
  - IDLE: tim_rst=1. On CEN becoming 1, go to ARM.
  - ARM: tim_rst=1 for exactly one cycle so the timer reloads its shadow period from the current ARR. Then go to RUN. If CEN is cleared during ARM, go to IDLE.
  - RUN: tim_rst=0. Go to IDLE when CEN=0.
  - tim_rst is registered from the state; the timer therefore first counts 2 cycles after the CEN write completes.
- Update-event detection (RUN only):
  - Register prev=tim_counter each cycle.
  - Event when tim_counter != prev and:
    - CMS=00: tim_counter==0;
    - CMS=01: prev==0;
    - CMS=10: tim_counter==0.
  - ARR=0 produces no events (counter static); this is a documented limitation.
  - No event is detected in the first RUN cycle, because prev is invalid.
- On an event: SR.UIF<=1. If CR.OPM=1, CEN<=0 in the same cycle, and the FSM enters IDLE next cycle.
- Simultaneous events:
  - A hardware UIF set and a SW W1C in the same cycle: the set wins.
  - A SW write of CR and an OPM auto-clear in the same cycle: CEN=0 wins; the other CR fields take the SW value.
- Reset asserted mid-run: all state returns to reset values on the next edge; tim_rst=1 immediately after.
- irq is combinational from registered SR/DIER.

Optional Feature:
TIM_CTRL_REPCNT_EN
- Defined:
  - RCR[7:0] is at 0x1C, reset 0.
  - An internal repetition down-counter loads RCR on ARM and on each flagged event.
  - Each detected event decrements it. UIF is set, and OPM stops the timer, only when the event occurs with the counter at 0, i.e. every RCR+1 events.
- Undefined: 0x1C reads 0 and writes are ignored; every event sets UIF.

Test Plan:
1. Reset, read all registers -> CR=0, ARR=0xFFFF, SR=0, CNT=0; tim_rst=1, irq=0; bus_ready exactly 1 cycle after every req.
2. PSC=0, ARR=4, CMS=00, UIE=1, write CEN=1 -> tim_rst low 2 cycles later; counter 0..4,0; UIF and irq set on the 4->0 step; W1C SR clears UIF; next wrap sets it again 5 cycles later.
3. CMS=01, ARR=3, OPM=1, CEN=1 -> one event on the 0->3 reload; CEN reads 0; tim_rst=1 the cycle after; CNT holds 0.
4. UIF W1C issued in the same cycle as a wrap -> UIF remains 1. CR write with CEN=1 in the same cycle as an OPM stop -> CEN reads 0.
5. CMS=10, ARR=2, run 12 cycles -> counter 0,1,2,1,0,1...; UIF set on each 1->0 step; CMS write of 3 reads back 0.
6. (TIM_CTRL_REPCNT_EN) RCR=2, CMS=00, ARR=1 -> UIF only on the 3rd wrap; without the macro, RCR reads 0 and UIF is set on the 1st wrap.
